// File: rtl/mmm_window_stream_if.sv
// Stream bundle for the 3-tap max/mid/min window block.
// Carries the sample stream in (in_valid/in_ready/in_data) and the result stream
// out (out_valid/out_ready/out_max/out_mid/out_min/out_seq).
// slave: the window block's view; master: the producer/consumer side.
interface mmm_window_stream_if #(
  parameter int WIDTH = 8,
  parameter int SEQ_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_mid;
  logic [WIDTH-1:0] out_min;
  logic [SEQ_W-1:0] out_seq;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_mid, out_min, out_seq
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_mid, out_min, out_seq
  );
endinterface

// File: rtl/mmm_window_stream.sv
// Purpose: sliding 3-sample window over a sample stream, emitting registered max/mid/min per sample.
// Latency: result visible the cycle after the sample that completes (or keeps) a full window is accepted.
// Backpressure: once the window is full, a held result with out_ready=0 deasserts in_ready.
// Ports: clk_i; rst_i (sync, active-high, clears everything incl. out_seq);
//        flush_i (sync window clear, keeps out_seq and last result values); bus (slave modport).
module mmm_window_stream #(
  parameter int WIDTH = 8,
  parameter int SEQ_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  mmm_window_stream_if.slave   bus
);

  typedef enum logic {FILL, RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       count_q, count_d;
  // Only the two newest samples are stored: the window used for a result is
  // {incoming sample, w0, w1}, so the oldest tap is shifted out on the same edge.
  logic [WIDTH-1:0] w0_q, w0_d;
  logic [WIDTH-1:0] w1_q, w1_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] mid_q, mid_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  logic             in_ready;
  logic             accept;
  logic             load;
  logic             consume;

  logic [WIDTH-1:0] s_hi1, s_lo1, s_lo2, s_max, s_mid, s_min;

  // count<2 covers fill samples that cannot produce a result and so never need a free output slot.
  assign in_ready = (count_q < 2'd2) | ~valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  // An accepted sample at count 2 completes the window; at count 3 it keeps it full.
  assign load     = accept & count_q[1];
  assign consume  = valid_q & bus.out_ready;

  // Three-input sort: order (in, w0), then place w1 against the larger, then
  // order the two remaining small values. Ties fall through consistently.
  always_comb begin
    s_hi1 = (bus.in_data > w0_q) ? bus.in_data : w0_q;
    s_lo1 = (bus.in_data > w0_q) ? w0_q : bus.in_data;
    s_max = (s_hi1 > w1_q) ? s_hi1 : w1_q;
    s_lo2 = (s_hi1 > w1_q) ? w1_q : s_hi1;
    s_mid = (s_lo1 > s_lo2) ? s_lo1 : s_lo2;
    s_min = (s_lo1 > s_lo2) ? s_lo2 : s_lo1;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    valid_d = valid_q;
    max_d   = max_q;
    mid_d   = mid_q;
    min_d   = min_q;
    seq_d   = seq_q;

    if (flush_i) begin
      // Flush beats any same-cycle handshake: the sample is dropped and a
      // pending result is discarded without advancing out_seq.
      state_d = FILL;
      count_d = 2'd0;
      w0_d    = '0;
      w1_d    = '0;
      valid_d = 1'b0;
    end else begin
      if (consume) begin
        valid_d = 1'b0;
        seq_d   = seq_q + 1'b1;
      end
      if (accept) begin
        w0_d = bus.in_data;
        w1_d = w0_q;
        if (count_q != 2'd3) begin
          count_d = count_q + 2'd1;
        end
      end
      if (load) begin
        valid_d = 1'b1;
        max_d   = s_max;
        mid_d   = s_mid;
        min_d   = s_min;
      end
      case (state_q)
        FILL:    if (load) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      count_q <= 2'd0;
      w0_q    <= '0;
      w1_q    <= '0;
      valid_q <= 1'b0;
      max_q   <= '0;
      mid_q   <= '0;
      min_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      valid_q <= valid_d;
      max_q   <= max_d;
      mid_q   <= mid_d;
      min_q   <= min_d;
      seq_q   <= seq_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_max   = max_q;
  assign bus.out_mid   = mid_q;
  assign bus.out_min   = min_q;
  assign bus.out_seq   = seq_q;

endmodule

// File: tb/tb_mmm_window_stream.sv
// Directed bench for mmm_window_stream: fill/latency, sliding window, ties,
// backpressure, flush, sequence wrap and mid-stream reset.
// Results are compared as {out_valid, out_max, out_mid, out_min, out_seq}.
module tb_mmm_window_stream;
  localparam int WIDTH = 8;
  localparam int SEQ_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  mmm_window_stream_if #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) bus ();

  mmm_window_stream #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] got;
  logic [32:0] exp;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_fill_latency();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'd10; step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_first: out_valid %b want 0", bus.out_valid); end
    bus.in_data = 8'd30; step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_second: out_valid %b want 0", bus.out_valid); end
    bus.in_data = 8'd20; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd30, 8'd20, 8'd10, 8'd0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fill_third: got %h want %h", got, exp); end
  endtask

  task automatic test_sliding();
    bus.in_data = 8'd5; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd30, 8'd20, 8'd5, 8'd1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL slide_5: got %h want %h", got, exp); end
    bus.in_data = 8'd40; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd40, 8'd20, 8'd5, 8'd2};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL slide_40: got %h want %h", got, exp); end
    bus.in_valid = 1'b0; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b0, 8'd40, 8'd20, 8'd5, 8'd3};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL slide_drain: got %h want %h", got, exp); end
  endtask

  task automatic test_duplicates();
    bus.in_valid = 1'b1;
    bus.in_data = 8'd7; step();
    bus.in_data = 8'd7; step();
    bus.in_data = 8'd3; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd7, 8'd7, 8'd3, 8'd5};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL dup_773: got %h want %h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'd9; step();
    end
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd9, 8'd9, 8'd9, 8'd8};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL dup_999: got %h want %h", got, exp); end
    bus.in_data = 8'd255; step();
    bus.in_data = 8'd0;   step();
    bus.in_data = 8'd128; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd255, 8'd128, 8'd0, 8'd11};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL extremes: got %h want %h", got, exp); end
  endtask

  task automatic test_backpressure();
    // Window is {128,0,255}; 50 gives (128,50,0).
    bus.in_data = 8'd50; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd128, 8'd50, 8'd0, 8'd12};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_load: got %h want %h", got, exp); end
    bus.out_ready = 1'b0;
    bus.in_data = 8'd60;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, bus.in_ready); end
      step();
      got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL bp_hold cycle %0d: got %h want %h", c, got, exp); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd128, 8'd60, 8'd50, 8'd13};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_release: got %h want %h", got, exp); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'd99;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b0, 8'd128, 8'd60, 8'd50, 8'd13};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL flush_clear: got %h want %h", got, exp); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    bus.in_data = 8'd1; step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_refill1: out_valid %b want 0", bus.out_valid); end
    bus.in_data = 8'd2; step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_refill2: out_valid %b want 0", bus.out_valid); end
    bus.in_data = 8'd3; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd3, 8'd2, 8'd1, 8'd13};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL flush_first_result: got %h want %h", got, exp); end
    bus.in_valid = 1'b0; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b0, 8'd3, 8'd2, 8'd1, 8'd14};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL flush_drain: got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [8:0] vs_got;
    logic [8:0] vs_exp;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.in_data = WIDTH'(i);
      step();
      vs_got = {bus.out_valid, bus.out_seq};
      vs_exp = {1'b1, SEQ_W'(14 + i)};
      n_checks++;
      if (vs_got !== vs_exp) begin n_fail++; $display("FAIL wrap_seq i=%0d: got %h want %h", i, vs_got, vs_exp); end
    end
    // Last window {0,255,254}; seq is (14+256) mod 256.
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd255, 8'd254, 8'd0, 8'd14};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL wrap_last: got %h want %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.in_data = 8'd77;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL midrst_outputs: got %h want %h", got, exp); end
    bus.in_data = 8'd4; step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fill1: out_valid %b want 0", bus.out_valid); end
    bus.in_data = 8'd6; step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fill2: out_valid %b want 0", bus.out_valid); end
    bus.in_data = 8'd5; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b1, 8'd6, 8'd5, 8'd4, 8'd0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL midrst_result: got %h want %h", got, exp); end
    bus.in_valid = 1'b0; step();
    got = {bus.out_valid, bus.out_max, bus.out_mid, bus.out_min, bus.out_seq};
    exp = {1'b0, 8'd6, 8'd5, 8'd4, 8'd1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL midrst_drain: got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_fill_latency();
    test_sliding();
    test_duplicates();
    test_backpressure();
    test_flush();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmm_window_stream.md
Name: mmm_window_stream

Overview:
- Streaming front end for the max/mid/min sorter.
- Accepts a serial stream of samples over a valid/ready handshake and keeps a sliding window of the three most recent samples.
- Once the window is full, each accepted sample produces one registered max/mid/min result over a downstream valid/ready handshake.
- Used as a 3-tap running median/extreme filter ahead of downstream consumers.

Parameters:
- WIDTH, 8: sample and result width in bits (unsigned).
- SEQ_W, 8: width of the output sequence tag.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous window clear; does not reset out_seq.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  sample value, unsigned.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_max  output  WIDTH  largest of the window.
- out_mid  output  WIDTH  middle of the window after sorting; duplicates are counted.
- out_min  output  WIDTH  smallest of the window.
- out_seq  output  SEQ_W  index of the result, starting at 0.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: out_valid=0, out_max=out_mid=out_min=0, out_seq=0, window registers w0/w1/w2=0, fill count=0.
- Window: accepting a sample (in_valid & in_ready) shifts w2<=w1, w1<=w0, w0<=in_data. The fill count increments and saturates at 3.
- States:
  - FILL (count<3).
  - RUN (count==3). Entered when the third sample is accepted.
  - RUN is left only by rst or flush, which return to FILL with count=0.
- in_ready:
  - Combinational: in_ready = (count<2) | ~out_valid | out_ready.
  - Samples during FILL that do not complete the window are always accepted.
- Result load: when an accepted sample makes or keeps count==3, the result register loads on the same edge:
  - sort of {in_data, w0, w1} into max/mid/min (the new window);
  - out_valid<=1.
- Latency: result is visible the cycle after the completing sample is accepted.
- Sort rules:
  - Unsigned compare.
  - Ties: equal values occupy consecutive sorted positions, e.g. {5,5,9} -> max 9, mid 5, min 5; all-equal gives three identical outputs.
- Output handshake:
  - out_valid & out_ready with no new load -> out_valid<=0 next cycle.
  - Simultaneous consume and load -> out_valid stays 1 and the new result replaces the old one. Full throughput: one result per cycle.
  - out_valid=1 & out_ready=0 -> in_ready=0 in RUN, and outputs hold stable.
- out_seq:
  - Increments by 1 on every handshake-completed result (out_valid & out_ready).
  - Wraps modulo 2^SEQ_W, e.g. 255 -> 0.
  - The value shown always equals the number of results previously consumed, mod 2^SEQ_W.
- flush:
  - Count<=0, out_valid<=0, w0..w2<=0 on the edge where flush=1.
  - Has priority over a same-cycle input handshake: the sample is dropped and not counted; the upstream sees it as accepted if in_ready was 1.
  - A pending unconsumed result is discarded and out_seq is not incremented.
- rst mid-operation: same as flush plus out_seq<=0. rst has priority over flush and all handshakes.
- in_data is ignored when in_valid=0. Output values are don't-care-free: they always hold the last loaded result, or 0 after reset.

Test Plan:
- Fill and latency: after reset, send 10, 30, 20 back-to-back with out_ready=1 -> no out_valid for the first two; the cycle after 20 is accepted: max=30, mid=20, min=10, seq=0.
- Sliding window: continue with 5, then 40 -> results (30,20,5) seq=1, then (40,20,5) seq=2; exactly one result per accepted sample.
- Duplicates: window 7, 7, 3 -> (7,7,3); window 9, 9, 9 -> (9,9,9); extremes 255, 0, 128 -> (255,128,0).
- Backpressure:
  - With out_valid=1, hold out_ready=0 for 4 cycles -> in_ready=0 and outputs stable.
  - Release with in_valid=1 -> the old result is consumed and the new one loaded on the same edge; out_valid stays 1.
- Flush:
  - Assert flush with in_valid=1 and a pending result -> out_valid=0 next cycle and count=0.
  - Then 1, 2, 3 -> the first result (3,2,1) appears only after 3 new samples; seq continues from the pre-flush value.
- Wrap and reset:
  - Stream 257 results with out_ready=1 -> out_seq wraps 255->0->1.
  - Assert rst mid-stream -> all outputs 0 the next cycle and FILL restarts.
